// File: rtl/data_bus.sv
// M-stage data port: byte-maskable data RAM plus an MMIO page with a buffered 8N1 UART TX and a
// 64-bit cycle counter. Defining DATA_BUS_EXIT_EN adds the EXIT register and halt/exit_code ports.
`timescale 1ns / 1ps

module data_bus #(
  parameter int unsigned RAM_WORDS     = 4096,
  parameter int unsigned CLK_DIV       = 868,
  parameter int unsigned TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  wmask,
  input  logic        wen,
  output logic [31:0] read_data,
  output logic        uart_tx
`ifdef DATA_BUS_EXIT_EN
  ,
  output logic        halt,
  output logic [31:0] exit_code
`endif
);

  localparam int unsigned AddrW = $clog2(RAM_WORDS);
  localparam int unsigned PtrW  = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic             sel_ram, sel_mmio;
  logic [9:0]       mmio_off;
  logic [AddrW-1:0] word_idx;
  logic             unused_addr;

  assign sel_ram     = (address[31:28] == 4'h0);
  assign sel_mmio    = (address[31:12] == 20'h10000);
  assign mmio_off    = address[11:2];
  assign word_idx    = address[AddrW+1:2];
  assign unused_addr = ^address[1:0];

  // Data RAM: not reset, byte-lane writes.
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wen && sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) ram_q[word_idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  // TX FIFO with an extra wrap bit on each pointer.
  logic [7:0]    fifo_q [TX_FIFO_DEPTH];
  logic [PtrW:0] wptr_q, rptr_q;
  logic          full, empty, push_req, push, pop;
  logic          ovf_q, ovf_clr, hi_snap;
  logic [63:0]   cyc_q;
  logic [31:0]   hi_q;
  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [BaudW-1:0] baud_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy;

  assign full     = ((wptr_q ^ rptr_q) == {1'b1, {PtrW{1'b0}}});
  assign empty    = (wptr_q == rptr_q);
  assign push_req = wen && sel_mmio && (mmio_off == 10'd0) && wmask[0];
  assign push     = push_req && !full;
  assign pop      = (state_q == StIdle) && !empty;
  assign ovf_clr  = wen && sel_mmio && (mmio_off == 10'd1) && wmask[0] && write_data[3];
  assign hi_snap  = !wen && sel_mmio && (mmio_off == 10'd2);
  assign busy     = (state_q != StIdle) || !empty;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[PtrW-1:0]] <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      cyc_q  <= '0;
      hi_q   <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (PtrW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (PtrW+1)'(1);
      // A dropped push beats a clear in the same cycle.
      if (push_req && full) ovf_q <= 1'b1;
      else if (ovf_clr)     ovf_q <= 1'b0;
      if (hi_snap) hi_q <= cyc_q[63:32];
      cyc_q <= cyc_q + 64'd1;
    end
  end

  // Serializer; tx_q is loaded with the level of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      baud_q    <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_q[rptr_q[PtrW-1:0]];
            baud_q  <= '0;
            state_q <= StStart;
            tx_q    <= 1'b0;
          end
        end
        StStart: begin
          if (baud_q == BaudMax) begin
            baud_q    <= '0;
            bit_cnt_q <= '0;
            state_q   <= StData;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_q == BaudMax) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_q == BaudMax) begin
            baud_q  <= '0;
            state_q <= StIdle;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_tx = tx_q;

`ifdef DATA_BUS_EXIT_EN
  logic        halt_q;
  logic [31:0] exit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_q <= 1'b0;
      exit_q <= '0;
    end else if (wen && sel_mmio && (mmio_off == 10'd4) && (wmask == 4'hF) && !halt_q) begin
      halt_q <= 1'b1;
      exit_q <= write_data;
    end
  end

  assign halt      = halt_q;
  assign exit_code = exit_q;
`endif

  always_comb begin
    read_data = '0;
    if (sel_ram) begin
      read_data = ram_q[word_idx];
    end else if (sel_mmio) begin
      case (mmio_off)
        10'd1:   read_data = {28'b0, ovf_q, empty, full, busy};
        10'd2:   read_data = cyc_q[31:0];
        10'd3:   read_data = hi_q;
`ifdef DATA_BUS_EXIT_EN
        10'd4:   read_data = {31'b0, halt_q};
`endif
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus.sv
// Randomized bench for data_bus against a frame/queue-level reference model, plus directed
// literal checks for RAM lanes, UART framing, FIFO overflow, cycle snapshot and reset abort.
`timescale 1ns / 1ps

module tb_data_bus;
  localparam int unsigned RamWords = 4096;
  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned Depth    = 8;
  localparam logic [31:0] TxAddr   = 32'h1000_0000;
  localparam logic [31:0] StAddr   = 32'h1000_0004;
  localparam logic [31:0] LoAddr   = 32'h1000_0008;
  localparam logic [31:0] HiAddr   = 32'h1000_000C;
  localparam logic [31:0] ExAddr   = 32'h1000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'h2000_0000;
  logic [31:0] write_data = '0;
  logic [3:0]  wmask = '0;
  logic        wen = 1'b0;
  logic [31:0] read_data;
  logic        uart_tx;
`ifdef DATA_BUS_EXIT_EN
  logic        halt;
  logic [31:0] exit_code;
`endif

  data_bus #(.RAM_WORDS(RamWords), .CLK_DIV(ClkDiv), .TX_FIFO_DEPTH(Depth)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .write_data (write_data),
    .wmask      (wmask),
    .wen        (wen),
    .read_data  (read_data),
    .uart_tx    (uart_tx)
`ifdef DATA_BUS_EXIT_EN
    ,
    .halt       (halt),
    .exit_code  (exit_code)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue for the FIFO, a frame position counter for the line.
  logic [31:0] m_ram [RamWords];
  bit          m_known [RamWords];
  logic [7:0]  m_q [$];
  bit          m_active = 1'b0;
  int          m_pos = 0;
  logic [7:0]  m_byte = '0;
  bit          m_ovf = 1'b0;
  logic [63:0] m_cyc = '0;
  logic [31:0] m_hi = '0;
  bit          m_halt = 1'b0;
  logic [31:0] m_exit = '0;

  function automatic bit f_ram(input logic [31:0] a);
    return a[31:28] == 4'h0;
  endfunction

  function automatic bit f_mmio(input logic [31:0] a);
    return a[31:12] == 20'h10000;
  endfunction

  function automatic int f_idx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic logic m_txf();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / ClkDiv;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    bit busy, emp, ful;
    busy = m_active || (m_q.size() != 0);
    emp  = (m_q.size() == 0);
    ful  = (m_q.size() == int'(Depth));
    return {28'b0, m_ovf, emp, ful, busy};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (f_ram(a)) return m_ram[f_idx(a)];
    if (!f_mmio(a)) return 32'h0;
    case (a[11:2])
      10'd1:   return m_status();
      10'd2:   return m_cyc[31:0];
      10'd3:   return m_hi;
`ifdef DATA_BUS_EXIT_EN
      10'd4:   return {31'b0, m_halt};
`endif
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      m_cyc    = '0;
      m_hi     = '0;
      m_halt   = 1'b0;
      m_exit   = '0;
    end else begin
      bit push_try, do_pop, mm;
      int sz;
      logic [9:0] off;
      mm  = f_mmio(address);
      off = address[11:2];
      sz  = m_q.size();
      push_try = wen && mm && (off == 10'd0) && wmask[0];
      do_pop   = !m_active && (sz > 0);
      if (wen && f_ram(address)) begin
        for (int i = 0; i < 4; i++)
          if (wmask[i]) m_ram[f_idx(address)][8*i +: 8] = write_data[8*i +: 8];
        if (wmask == 4'hF) m_known[f_idx(address)] = 1'b1;
      end
      if (push_try && sz >= int'(Depth)) m_ovf = 1'b1;
      else if (wen && mm && off == 10'd1 && wmask[0] && write_data[3]) m_ovf = 1'b0;
      if (!wen && mm && off == 10'd2) m_hi = m_cyc[63:32];
`ifdef DATA_BUS_EXIT_EN
      if (wen && mm && off == 10'd4 && wmask == 4'hF && !m_halt) begin
        m_halt = 1'b1;
        m_exit = write_data;
      end
`endif
      m_cyc = m_cyc + 64'd1;
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * int'(ClkDiv)) m_active = 1'b0;
      end else if (do_pop) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (push_try && sz < int'(Depth)) m_q.push_back(write_data[7:0]);
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      if (!(f_ram(address) && !m_known[f_idx(address)]))
        chk("read_data", read_data, m_read(address));
      chk("uart_tx", {31'b0, uart_tx}, {31'b0, m_txf()});
`ifdef DATA_BUS_EXIT_EN
      chk("halt", {31'b0, halt}, {31'b0, m_halt});
      chk("exit_code", exit_code, m_exit);
`endif
    end
  end

  // Line receiver: first negedge sample of each bit.
  int         rx_count = 0;
  logic [7:0] rx_last = '0;
  initial forever begin
    @(negedge clk);
    if (reset && uart_tx === 1'b0) begin
      logic [7:0] b;
      b = '0;
      for (int k = 0; k < 8; k++) begin
        repeat (ClkDiv) @(negedge clk);
        b[k] = uart_tx;
      end
      repeat (ClkDiv) @(negedge clk);
      rx_count++;
      rx_last = b;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic w);
    address = a; write_data = d; wmask = m; wen = w;
    @(posedge clk); #1;
    wen = 1'b0; wmask = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    address = a; wen = 1'b0; wmask = '0;
    @(negedge clk);
    chk(nm, read_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    address = StAddr; wen = 1'b0; wmask = '0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (read_data[0] === 1'b0) ok = 1'b1;
      @(posedge clk); #1;
    end
    chk(nm, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int base;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'b0, uart_tx}, 32'd1);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    rd(StAddr, 32'h4, "rst_status");
    rd(HiAddr, 32'h0, "rst_hi");

    for (int w = 0; w < 16; w++) do_op(32'h100 + 32'(w * 4), $urandom, 4'hF, 1'b1);

    do_op(32'h100, 32'h1122_3344, 4'hF, 1'b1);
    do_op(32'h100, 32'h00AA_0000, 4'b0100, 1'b1);
    do_op(32'h104, 32'hDEAD_BEEF, 4'h0, 1'b1);
    rd(32'h100, 32'h11AA_3344, "ram_lane");
    rd(32'h4100, 32'h11AA_3344, "ram_alias");

    rd(LoAddr, m_cyc[31:0], "cyc_lo");
    rd(HiAddr, 32'h0, "cyc_hi");
    rd(32'h2000_0000, 32'h0, "unmapped");
    rd(32'h1000_1004, 32'h0, "unmapped_page");

    // One 0x55 frame sampled cycle by cycle.
    do_op(TxAddr, 32'h55, 4'b0001, 1'b1);
    address = StAddr;
    for (int i = 0; i <= 40; i++) begin
      int  k;
      logic e;
      logic [7:0] pat;
      pat = 8'h55;
      @(negedge clk);
      k = (i - 1) / int'(ClkDiv);
      e = (i == 0) ? 1'b1 : (k == 0) ? 1'b0 : (k <= 8) ? pat[k-1] : 1'b1;
      chk("frame_bit", {31'b0, uart_tx}, {31'b0, e});
      chk("frame_status", read_data, (i == 0) ? 32'h1 : 32'h5);
    end
    @(negedge clk);
    chk("frame_done", read_data, 32'h4);
    @(posedge clk); #1;
    chk("rx_55", {24'b0, rx_last}, 32'h55);

    base = rx_count;
    for (int i = 0; i < 10; i++) do_op(TxAddr, 32'hA0 + 32'(i), 4'b0001, 1'b1);
    rd(StAddr, 32'hB, "ovf_status");
    do_op(StAddr, 32'h8, 4'b0001, 1'b1);
    rd(StAddr, 32'h3, "ovf_clear");
    wait_idle("ovf_drain");
    chk("ovf_frames", 32'(rx_count - base), 32'd9);
    chk("ovf_last", {24'b0, rx_last}, 32'hA8);
    rd(StAddr, 32'h4, "ovf_idle");

`ifdef DATA_BUS_EXIT_EN
    do_op(ExAddr, 32'h2A, 4'hF, 1'b1);
    @(negedge clk);
    chk("exit_halt", {31'b0, halt}, 32'd1);
    chk("exit_code", exit_code, 32'd42);
    @(posedge clk); #1;
    do_op(ExAddr, 32'h1, 4'hF, 1'b1);
    rd(ExAddr, 32'h1, "exit_read");
    chk("exit_sticky", exit_code, 32'd42);
`else
    do_op(ExAddr, 32'h2A, 4'hF, 1'b1);
    rd(ExAddr, 32'h0, "exit_unmapped");
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      logic [3:0]  m;
      logic        w;
      int          r;
      r = int'($urandom_range(0, 99));
      d = $urandom;
      m = 4'($urandom);
      w = 1'($urandom);
      if (r < 35) begin
        a = {4'h0, 14'($urandom), 12'(12'h040 + 12'($urandom_range(0, 15))), 2'($urandom)};
      end else if (r < 45) begin
        a = TxAddr | 32'($urandom_range(0, 3));
        w = 1'b1;
      end else if (r < 60) begin
        a = StAddr | 32'($urandom_range(0, 3));
      end else if (r < 75) begin
        a = ($urandom_range(0, 1) == 0) ? LoAddr : HiAddr;
      end else if (r < 85) begin
        a = ExAddr;
        if ($urandom_range(0, 3) == 0) m = 4'hF;
      end else if (r < 92) begin
        a = 32'h1000_0000 | (32'($urandom_range(5, 1023)) << 2);
      end else begin
        a = $urandom;
        if (a[31:28] == 4'h0) a[31:28] = 4'h2;
        if (a[31:12] == 20'h10000) a[12] = 1'b1;
      end
      do_op(a, d, m, w);
    end

    wait_idle("rand_drain");

    // Abort a frame mid DATA bit with an all-zero byte.
    do_op(TxAddr, 32'h00, 4'b0001, 1'b1);
    address = StAddr;
    repeat (7) @(posedge clk);
    #1 chk("abort_pre", {31'b0, uart_tx}, 32'd0);
    #1 reset = 1'b0;
    #1 chk("abort_tx", {31'b0, uart_tx}, 32'd1);
    chk("abort_status", read_data, 32'h4);
    address = LoAddr;
    #1 chk("abort_cyc", read_data, 32'h0);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("restart_cyc0", read_data, 32'h0);
    @(negedge clk);
    chk("restart_cyc1", read_data, 32'h1);
    @(posedge clk); #1;
    rd(StAddr, 32'h4, "restart_status");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
